ram_access_arbiter: RTL and testbench

RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/ram_access_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_access_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared defaults and helpers for the RAM access arbiter
package ram_arb_pkg;

   localparam int REQ_NUM_DEFAULT = 4;

   function automatic int id_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) idx = oh[i[2:0]] ? (idx | 3'(i)) : idx;
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at the priority pointer
module rr_arbiter import ram_arb_pkg::*; #(
   parameter int N  = REQ_NUM_DEFAULT,
   parameter int IW = id_width(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   logic [N-1:0] w_mask;
   logic [N-1:0] w_hi;
   logic [N-1:0] w_pick;

   genvar j;
   for (j = 0; j < N; j++) begin : g_mask
      assign w_mask[j] = IW'(j) >= i_ptr;
   end

   // requesters at or above the pointer win; otherwise wrap to the lowest one
   always_comb begin
      w_hi   = i_req & w_mask;
      w_pick = (|w_hi) ? w_hi : i_req;
      o_gnt  = w_pick & (~w_pick + N'(1));
      o_idx  = IW'(onehot_to_idx(8'(o_gnt)));
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: independent round-robin write/read arbitration onto one RAM
module ram_access_arbiter import ram_arb_pkg::*; #(
   parameter  int REQ_NUM          = REQ_NUM_DEFAULT,
   parameter  int DATA_WIDTH       = 32,
   parameter  int ADDR_WIDTH       = 8,
   localparam int BYTE_VALID_WIDTH = DATA_WIDTH / 8,
   localparam int ID_WIDTH         = id_width(REQ_NUM)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [REQ_NUM-1:0]                  wr_req,
   input  logic [REQ_NUM*ADDR_WIDTH-1:0]       wr_req_addr,
   input  logic [REQ_NUM*DATA_WIDTH-1:0]       wr_req_data,
   input  logic [REQ_NUM*BYTE_VALID_WIDTH-1:0] wr_req_byte_valid,
   output logic [REQ_NUM-1:0]                  wr_gnt,
   input  logic [REQ_NUM-1:0]                  rd_req,
   input  logic [REQ_NUM*ADDR_WIDTH-1:0]       rd_req_addr,
   output logic [REQ_NUM-1:0]                  rd_gnt,
   output logic                                rd_resp_valid,
   output logic [ID_WIDTH-1:0]                 rd_resp_id,
   output logic [DATA_WIDTH-1:0]               rd_resp_data,
   output logic                                ram_wr_en,
   output logic [ADDR_WIDTH-1:0]               ram_wr_addr,
   output logic [DATA_WIDTH-1:0]               ram_wr_data,
   output logic [BYTE_VALID_WIDTH-1:0]         ram_wr_byte_valid,
   output logic                                ram_rd_en,
   output logic [ADDR_WIDTH-1:0]               ram_rd_addr,
   input  logic [DATA_WIDTH-1:0]               ram_rd_data,
   input  logic                                ram_rd_data_valid
);

   logic [ADDR_WIDTH-1:0]       w_wr_addr [REQ_NUM];
   logic [DATA_WIDTH-1:0]       w_wr_data [REQ_NUM];
   logic [BYTE_VALID_WIDTH-1:0] w_wr_bv   [REQ_NUM];
   logic [ADDR_WIDTH-1:0]       w_rd_addr [REQ_NUM];
   logic [REQ_NUM-1:0]          w_wr_sel;
   logic [REQ_NUM-1:0]          w_rd_sel;
   logic [ID_WIDTH-1:0]         w_wr_idx;
   logic [ID_WIDTH-1:0]         w_rd_idx;
   logic                        w_hazard;
   logic                        w_wr_any;
   logic                        w_rd_any;
   logic [ID_WIDTH-1:0]         r_wr_ptr;
   logic [ID_WIDTH-1:0]         r_rd_ptr;
   logic                        r_ram_wr_en;
   logic [ADDR_WIDTH-1:0]       r_ram_wr_addr;
   logic [DATA_WIDTH-1:0]       r_ram_wr_data;
   logic [BYTE_VALID_WIDTH-1:0] r_ram_wr_bv;
   logic                        r_ram_rd_en;
   logic [ADDR_WIDTH-1:0]       r_ram_rd_addr;
   logic [1:0]                  r_vld;
   logic [ID_WIDTH-1:0]         r_id0;
   logic [ID_WIDTH-1:0]         r_id1;

   genvar j;
   for (j = 0; j < REQ_NUM; j++) begin : g_unpack
      assign w_wr_addr[j] = wr_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wr_data[j] = wr_req_data[j*DATA_WIDTH +: DATA_WIDTH];
      assign w_wr_bv[j]   = wr_req_byte_valid[j*BYTE_VALID_WIDTH +: BYTE_VALID_WIDTH];
      assign w_rd_addr[j] = rd_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
   end

   rr_arbiter #(.N(REQ_NUM), .IW(ID_WIDTH)) u_wr_arb (
      .i_req (wr_req),
      .i_ptr (r_wr_ptr),
      .o_gnt (w_wr_sel),
      .o_idx (w_wr_idx)
   );

   rr_arbiter #(.N(REQ_NUM), .IW(ID_WIDTH)) u_rd_arb (
      .i_req (rd_req),
      .i_ptr (r_rd_ptr),
      .o_gnt (w_rd_sel),
      .o_idx (w_rd_idx)
   );

   // a read colliding with this cycle's write waits so it sees the written data
   always_comb begin
      w_hazard = (|w_wr_sel) & (|w_rd_sel) & (w_rd_addr[w_rd_idx] == w_wr_addr[w_wr_idx]);
      wr_gnt   = rst ? '0 : w_wr_sel;
      rd_gnt   = (rst | w_hazard) ? '0 : w_rd_sel;
      w_wr_any = |wr_gnt;
      w_rd_any = |rd_gnt;
   end

   // priority pointers advance past the last granted requester
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_any) r_wr_ptr <= (w_wr_idx == ID_WIDTH'(REQ_NUM - 1)) ? '0 : w_wr_idx + ID_WIDTH'(1);
         if (w_rd_any) r_rd_ptr <= (w_rd_idx == ID_WIDTH'(REQ_NUM - 1)) ? '0 : w_rd_idx + ID_WIDTH'(1);
      end
   end

   // registered RAM write port; fields hold while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ram_wr_en   <= 1'b0;
         r_ram_wr_addr <= '0;
         r_ram_wr_data <= '0;
         r_ram_wr_bv   <= '0;
      end else begin
         r_ram_wr_en <= w_wr_any;
         if (w_wr_any) begin
            r_ram_wr_addr <= w_wr_addr[w_wr_idx];
            r_ram_wr_data <= w_wr_data[w_wr_idx];
            r_ram_wr_bv   <= w_wr_bv[w_wr_idx];
         end
      end
   end

   // registered RAM read port plus id/valid pipeline aligned to RAM latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ram_rd_en   <= 1'b0;
         r_ram_rd_addr <= '0;
         r_vld         <= '0;
         r_id0         <= '0;
         r_id1         <= '0;
      end else begin
         r_ram_rd_en <= w_rd_any;
         r_vld       <= {r_vld[0], w_rd_any};
         r_id1       <= r_id0;
         if (w_rd_any) begin
            r_ram_rd_addr <= w_rd_addr[w_rd_idx];
            r_id0         <= w_rd_idx;
         end
      end
   end

   assign ram_wr_en         = r_ram_wr_en;
   assign ram_wr_addr       = r_ram_wr_addr;
   assign ram_wr_data       = r_ram_wr_data;
   assign ram_wr_byte_valid = r_ram_wr_bv;
   assign ram_rd_en         = r_ram_rd_en;
   assign ram_rd_addr       = r_ram_rd_addr;
   assign rd_resp_valid     = r_vld[1] & ram_rd_data_valid;
   assign rd_resp_id        = r_id1;
   assign rd_resp_data      = ram_rd_data;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed scoreboard bench with a one-cycle-latency RAM model
module tb_ram_access_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int BW = 4;
   localparam int IW = 2;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
   } resp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    wr_req;
   logic [N*AW-1:0] wr_req_addr;
   logic [N*DW-1:0] wr_req_data;
   logic [N*BW-1:0] wr_req_byte_valid;
   logic [N-1:0]    wr_gnt;
   logic [N-1:0]    rd_req;
   logic [N*AW-1:0] rd_req_addr;
   logic [N-1:0]    rd_gnt;
   logic            rd_resp_valid;
   logic [IW-1:0]   rd_resp_id;
   logic [DW-1:0]   rd_resp_data;
   logic            ram_wr_en;
   logic [AW-1:0]   ram_wr_addr;
   logic [DW-1:0]   ram_wr_data;
   logic [BW-1:0]   ram_wr_byte_valid;
   logic            ram_rd_en;
   logic [AW-1:0]   ram_rd_addr;
   logic [DW-1:0]   ram_rd_data;
   logic            ram_rd_data_valid;

   logic [DW-1:0] mem [256];
   resp_t         q[$];
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   ram_access_arbiter dut (
      .clk               (clk),
      .rst               (rst),
      .wr_req            (wr_req),
      .wr_req_addr       (wr_req_addr),
      .wr_req_data       (wr_req_data),
      .wr_req_byte_valid (wr_req_byte_valid),
      .wr_gnt            (wr_gnt),
      .rd_req            (rd_req),
      .rd_req_addr       (rd_req_addr),
      .rd_gnt            (rd_gnt),
      .rd_resp_valid     (rd_resp_valid),
      .rd_resp_id        (rd_resp_id),
      .rd_resp_data      (rd_resp_data),
      .ram_wr_en         (ram_wr_en),
      .ram_wr_addr       (ram_wr_addr),
      .ram_wr_data       (ram_wr_data),
      .ram_wr_byte_valid (ram_wr_byte_valid),
      .ram_rd_en         (ram_rd_en),
      .ram_rd_addr       (ram_rd_addr),
      .ram_rd_data       (ram_rd_data),
      .ram_rd_data_valid (ram_rd_data_valid)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
      wr_req_addr[i*AW +: AW]       = a;
      wr_req_data[i*DW +: DW]       = d;
      wr_req_byte_valid[i*BW +: BW] = b;
      wr_req                        = wr_req | N'(1 << i);
   endtask

   task automatic set_rd_addr(input int i, input logic [AW-1:0] a);
      rd_req_addr[i*AW +: AW] = a;
   endtask

   function automatic logic [DW-1:0] dflt(input int a);
      return 32'hA500_0000 | DW'(a);
   endfunction

   // RAM model: byte-masked writes, registered read data one cycle after ram_rd_en
   initial begin
      logic [DW-1:0] rdv;
      for (int i = 0; i < 256; i++) mem[i] = dflt(i);
      ram_rd_data       = '0;
      ram_rd_data_valid = 1'b0;
      forever begin
         @(posedge clk);
         rdv = mem[ram_rd_addr];
         if (ram_wr_en === 1'b1)
            for (int b = 0; b < BW; b++)
               if (ram_wr_byte_valid[b]) mem[ram_wr_addr][8*b +: 8] = ram_wr_data[8*b +: 8];
         if (ram_rd_en === 1'b1) ram_rd_data <= rdv;
         ram_rd_data_valid <= (ram_rd_en === 1'b1);
      end
   end

   // response checker: every rd_resp_valid must match the oldest expected response
   always @(negedge clk) begin
      if (rd_resp_valid !== 1'b0) begin
         if (q.size() == 0) chk("unexpected_rd_resp_valid", DW'(rd_resp_valid), '0);
         else begin
            resp_t e;
            e = q.pop_front();
            chk("rd_resp_id", DW'(rd_resp_id), DW'(e.id));
            chk("rd_resp_data", rd_resp_data, e.data);
         end
      end
   end

   initial begin
      rst               = 1'b1;
      wr_req            = '0;
      rd_req            = '0;
      wr_req_addr       = '0;
      wr_req_data       = '0;
      wr_req_byte_valid = '0;
      rd_req_addr       = '0;
      tick;
      wr_req = 4'b1111;
      rd_req = 4'b1111;
      tick;
      #1;
      chk("rst_wr_gnt", DW'(wr_gnt), '0);
      chk("rst_rd_gnt", DW'(rd_gnt), '0);
      chk("rst_ram_wr_en", DW'(ram_wr_en), '0);
      chk("rst_ram_rd_en", DW'(ram_rd_en), '0);
      chk("rst_rd_resp_valid", DW'(rd_resp_valid), '0);
      chk("rst_rd_resp_id", DW'(rd_resp_id), '0);
      chk("rst_ram_wr_addr", DW'(ram_wr_addr), '0);
      chk("rst_ram_wr_data", ram_wr_data, '0);
      chk("rst_ram_rd_addr", DW'(ram_rd_addr), '0);
      wr_req = '0;
      rd_req = '0;
      tick;
      rst = 1'b0;
      tick;
      // single write through to the RAM port
      set_wr(0, 8'h10, 32'hDEADBEEF, 4'hF);
      #1;
      chk("t1_wr_gnt", DW'(wr_gnt), 32'b0001);
      chk("t1_rd_gnt_idle", DW'(rd_gnt), '0);
      tick;
      wr_req = '0;
      chk("t1_ram_wr_en", DW'(ram_wr_en), 1);
      chk("t1_ram_wr_addr", DW'(ram_wr_addr), 32'h10);
      chk("t1_ram_wr_data", ram_wr_data, 32'hDEADBEEF);
      chk("t1_ram_wr_bv", DW'(ram_wr_byte_valid), 32'hF);
      chk("t1_ram_rd_en_idle", DW'(ram_rd_en), '0);
      tick;
      chk("t1_ram_wr_en_pulse", DW'(ram_wr_en), '0);
      chk("t1_ram_wr_addr_hold", DW'(ram_wr_addr), 32'h10);
      // all readers requesting continuously rotate through the pointer
      for (int i = 0; i < N; i++) set_rd_addr(i, AW'(8'h10 + i));
      rd_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t2_rd_gnt", DW'(rd_gnt), DW'(1 << (k % 4)));
         q.push_back('{id: IW'(k % 4), data: (k % 4 == 0) ? 32'hDEADBEEF : dflt(8'h10 + k % 4)});
         tick;
      end
      rd_req = '0;
      repeat (3) tick;
      // read/write address hazard delays the read one cycle
      set_wr(1, 8'h20, 32'h12345678, 4'hF);
      set_rd_addr(2, 8'h20);
      rd_req = 4'b0100;
      #1;
      chk("t3_wr_gnt", DW'(wr_gnt), 32'b0010);
      chk("t3_rd_gnt_withheld", DW'(rd_gnt), '0);
      tick;
      wr_req = '0;
      #1;
      chk("t3_ram_wr_en", DW'(ram_wr_en), 1);
      chk("t3_rd_gnt_late", DW'(rd_gnt), 32'b0100);
      q.push_back('{id: IW'(2), data: 32'h12345678});
      tick;
      rd_req = '0;
      repeat (3) tick;
      // different addresses: write and read granted together
      set_wr(0, 8'h30, 32'h0BADF00D, 4'hF);
      set_rd_addr(3, 8'h31);
      rd_req = 4'b1000;
      #1;
      chk("t4_wr_gnt", DW'(wr_gnt), 32'b0001);
      chk("t4_rd_gnt", DW'(rd_gnt), 32'b1000);
      q.push_back('{id: IW'(3), data: dflt(8'h31)});
      tick;
      wr_req = '0;
      rd_req = '0;
      chk("t4_ram_wr_en", DW'(ram_wr_en), 1);
      chk("t4_ram_rd_en", DW'(ram_rd_en), 1);
      chk("t4_ram_wr_addr", DW'(ram_wr_addr), 32'h30);
      chk("t4_ram_rd_addr", DW'(ram_rd_addr), 32'h31);
      repeat (3) tick;
      // partial byte write then read back the merged word
      set_wr(0, 8'h40, 32'h11223344, 4'b0011);
      #1;
      chk("t5_wr_gnt", DW'(wr_gnt), 32'b0001);
      tick;
      wr_req = '0;
      chk("t5_ram_wr_bv", DW'(ram_wr_byte_valid), 32'b0011);
      tick;
      set_rd_addr(0, 8'h40);
      rd_req = 4'b0001;
      #1;
      chk("t5_rd_gnt", DW'(rd_gnt), 32'b0001);
      q.push_back('{id: IW'(0), data: 32'hA5003344});
      tick;
      rd_req = '0;
      repeat (3) tick;
      // write contention rotates from pointer 1
      for (int i = 0; i < N; i++) set_wr(i, AW'(8'h50 + i), dflt(8'h50 + i), 4'hF);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t6_wr_gnt", DW'(wr_gnt), DW'(1 << ((k + 1) % 4)));
         tick;
      end
      wr_req = '0;
      tick;
      // reset with a read in flight: response dropped, pointers back to 0
      set_rd_addr(0, 8'h12);
      rd_req = 4'b0001;
      #1;
      chk("t7_rd_gnt", DW'(rd_gnt), 32'b0001);
      tick;
      rd_req = '0;
      rst    = 1'b1;
      #1;
      chk("t7_rst_ram_rd_en", DW'(ram_rd_en), '0);
      chk("t7_rst_rd_resp_valid", DW'(rd_resp_valid), '0);
      tick;
      tick;
      rst = 1'b0;
      tick;
      wr_req = 4'b1111;
      rd_req = 4'b1111;
      #1;
      chk("t7_post_rst_rd_gnt", DW'(rd_gnt), 32'b0001);
      chk("t7_post_rst_wr_gnt", DW'(wr_gnt), 32'b0001);
      q.push_back('{id: IW'(0), data: dflt(8'h12)});
      tick;
      wr_req = '0;
      rd_req = '0;
      repeat (4) tick;
      chk("scoreboard_drained", DW'(q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
